// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store path and a
//   second requester (DMA/debug). One access per cycle. Contention is resolved
//   round-robin. Load data comes back one cycle after the grant, with a valid
//   strobe.
//
//   Handshake: a requester raises req with we/addr/wdata stable and holds them
//   until it sees gnt in the same cycle. The access is accepted in that cycle.
//   The requester may drop req before it is granted, and nothing happens.
//
//   Build option: DMEM_ARB_CPU_PRIORITY_EN
//     defined   -> fixed priority. The CPU always wins contention.
//     undefined -> round-robin. The side that was not granted last wins a tie.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   cpuReq/We/Addr/Wdata        CPU request in
//   cpuGnt/Stall/Rvalid/Rdata   CPU grant, stall, load return
//   dmaReq/We/Addr/Wdata        DMA request in
//   dmaGnt/Rvalid/Rdata         DMA grant, load return
//   memIndex/WrtEn/DataIn       to DMemController
//   memDataOut                  from DMemController (valid 1 cycle after index)
//   errOob                      sticky out-of-range flag
//   dbgLastGnt                  debug view of the arbiter state (1 = DMA last)
module dmem_arbiter #(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 13,
  parameter int DMEMWORDBITS = 2,
  parameter int DMEMWORDS    = 2048
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpuReq,
  input  logic                             cpuWe,
  input  logic [DBITS-1:0]                 cpuAddr,
  input  logic [DBITS-1:0]                 cpuWdata,
  output logic                             cpuGnt,
  output logic                             cpuStall,
  output logic                             cpuRvalid,
  output logic [DBITS-1:0]                 cpuRdata,
  input  logic                             dmaReq,
  input  logic                             dmaWe,
  input  logic [DBITS-1:0]                 dmaAddr,
  input  logic [DBITS-1:0]                 dmaWdata,
  output logic                             dmaGnt,
  output logic                             dmaRvalid,
  output logic [DBITS-1:0]                 dmaRdata,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] memIndex,
  output logic                             memWrtEn,
  output logic [DBITS-1:0]                 memDataIn,
  input  logic [DBITS-1:0]                 memDataOut,
  output logic                             errOob,
  output logic [0:0]                       dbgLastGnt
);

  localparam int IW = DMEMADDRBITS - DMEMWORDBITS;
  localparam logic [0:0] LAST_CPU = 1'b0;
  localparam logic [0:0] LAST_DMA = 1'b1;
  localparam logic [DBITS-1:0] WORDS_LIM = DBITS'(DMEMWORDS);

  logic [0:0]       last_gnt;
  logic [IW-1:0]    index_q;
  logic             cpu_pend, dma_pend, pend_oob, err_q;
  logic [DBITS-1:0] cpu_hold, dma_hold;

  logic             gnt_cpu, gnt_dma, any_gnt;
  logic             sel_we, sel_oob;
  logic [DBITS-1:0] sel_addr, sel_wdata, load_data;

  // Arbitration. No grants are issued while reset is high.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!reset) begin
      if (cpuReq && dmaReq) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        gnt_cpu = 1'b1;
`else
        if (last_gnt == LAST_DMA) gnt_cpu = 1'b1;
        else                      gnt_dma = 1'b1;
`endif
      end else begin
        gnt_cpu = cpuReq;
        gnt_dma = dmaReq;
      end
    end
  end

  assign any_gnt   = gnt_cpu | gnt_dma;
  assign sel_we    = gnt_dma ? dmaWe    : cpuWe;
  assign sel_addr  = gnt_dma ? dmaAddr  : cpuAddr;
  assign sel_wdata = gnt_dma ? dmaWdata : cpuWdata;

  // The range check uses the full word address, not the truncated index.
  // An address just past the implemented words (e.g. 0x2000) would
  // otherwise alias onto word 0 instead of being flagged.
  assign sel_oob = (sel_addr >> DMEMWORDBITS) >= WORDS_LIM;

  assign cpuGnt    = gnt_cpu;
  assign dmaGnt    = gnt_dma;
  assign cpuStall  = cpuReq & ~gnt_cpu;
  assign memWrtEn  = any_gnt & sel_we & ~sel_oob;
  assign memDataIn = any_gnt ? sel_wdata : '0;
  assign memIndex  = any_gnt ? sel_addr[DMEMADDRBITS-1:DMEMWORDBITS]
                   : (reset ? '0 : index_q);

  // An out-of-range load still completes, but it returns zero
  // instead of whatever the memory happens to present.
  assign load_data = pend_oob ? '0 : memDataOut;

  // Reset masks outputs combinationally. A load granted in the cycle
  // before reset therefore never shows its valid pulse.
  assign cpuRvalid = cpu_pend & ~reset;
  assign dmaRvalid = dma_pend & ~reset;
  assign cpuRdata  = reset ? '0 : (cpuRvalid ? load_data : cpu_hold);
  assign dmaRdata  = reset ? '0 : (dmaRvalid ? load_data : dma_hold);
  assign errOob    = err_q & ~reset;
  assign dbgLastGnt = last_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= LAST_DMA;
      index_q  <= '0;
      cpu_pend <= 1'b0;
      dma_pend <= 1'b0;
      pend_oob <= 1'b0;
      err_q    <= 1'b0;
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (any_gnt) begin
        last_gnt <= gnt_dma ? LAST_DMA : LAST_CPU;
        index_q  <= sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
        if (sel_oob) err_q <= 1'b1;
      end
      cpu_pend <= gnt_cpu & ~cpuWe;
      dma_pend <= gnt_dma & ~dmaWe;
      pend_oob <= sel_oob;
      if (cpuRvalid) cpu_hold <= load_data;
      if (dmaRvalid) dma_hold <= load_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cpuReq = 0, cpuWe = 0, dmaReq = 0, dmaWe = 0;
  logic [31:0] cpuAddr = 0, cpuWdata = 0, dmaAddr = 0, dmaWdata = 0;
  logic        cpuGnt, cpuStall, cpuRvalid, dmaGnt, dmaRvalid;
  logic [31:0] cpuRdata, dmaRdata, memDataIn;
  logic [31:0] memDataOut = 0;
  logic [10:0] memIndex;
  logic        memWrtEn, errOob;
  logic [0:0]  dbgLastGnt;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuGnt(cpuGnt), .cpuStall(cpuStall), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
    .dmaGnt(dmaGnt), .dmaRvalid(dmaRvalid), .dmaRdata(dmaRdata),
    .memIndex(memIndex), .memWrtEn(memWrtEn), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .errOob(errOob), .dbgLastGnt(dbgLastGnt)
  );

  // Data memory behind the arbiter: synchronous read, one cycle of latency.
  logic [31:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = '0;
  always @(posedge clk) begin
    memDataOut <= mem[memIndex];
    if (memWrtEn) mem[memIndex] <= memDataIn;
  end

  // ---------------- counters / compare helper ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [31:0] m_mem [0:2047];
  initial for (int i = 0; i < 2048; i++) m_mem[i] = '0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic        m_last_dma = 1'b1;
  logic [10:0] m_idx      = '0;
  logic        m_err      = 1'b0;
  logic [31:0] m_cpu_hold = '0, m_dma_hold = '0;

  // Every cycle: derive what the outputs must be from the current requests
  // and the model state, compare, then advance the model to the next edge.
  always begin : compare_proc
    logic        e_cg, e_dg, any, g_we, g_oob, e_cr, e_dr;
    logic [31:0] g_addr, g_wdata, e_crd, e_drd;
    logic [10:0] e_idx;
    @(negedge clk);
    #2;
    e_cg = 0; e_dg = 0;
    if (!reset) begin
      if (cpuReq && dmaReq) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        e_cg = 1;
`else
        e_cg = m_last_dma;
        e_dg = !m_last_dma;
`endif
      end else begin
        e_cg = cpuReq;
        e_dg = dmaReq;
      end
    end
    any     = e_cg || e_dg;
    g_addr  = e_dg ? dmaAddr  : cpuAddr;
    g_wdata = e_dg ? dmaWdata : cpuWdata;
    g_we    = e_dg ? dmaWe    : cpuWe;
    g_oob   = (g_addr / 4) >= 2048;
    e_idx   = any ? 11'((g_addr / 4) % 2048) : (reset ? 11'd0 : m_idx);
    e_cr    = !reset && cpu_q.size() != 0;
    e_dr    = !reset && dma_q.size() != 0;
    e_crd   = reset ? 32'd0 : (e_cr ? cpu_q[0] : m_cpu_hold);
    e_drd   = reset ? 32'd0 : (e_dr ? dma_q[0] : m_dma_hold);

    chk("cpu_gnt", 32'(cpuGnt), 32'(e_cg));
    chk("dma_gnt", 32'(dmaGnt), 32'(e_dg));
    chk("cpu_stall", 32'(cpuStall), 32'(cpuReq && !e_cg));
    chk("cpu_rvalid", 32'(cpuRvalid), 32'(e_cr));
    chk("dma_rvalid", 32'(dmaRvalid), 32'(e_dr));
    chk("cpu_rdata", cpuRdata, e_crd);
    chk("dma_rdata", dmaRdata, e_drd);
    chk("mem_index", 32'(memIndex), 32'(e_idx));
    chk("mem_wrt_en", 32'(memWrtEn), 32'(any && g_we && !g_oob));
    chk("err_oob", 32'(errOob), 32'(!reset && m_err));
    if (any) chk("mem_data_in", memDataIn, g_wdata);
    if (!reset) chk("last_gnt", 32'(dbgLastGnt), 32'(m_last_dma));

    if (reset) begin
      cpu_q.delete(); dma_q.delete();
      m_last_dma = 1; m_idx = 0; m_err = 0; m_cpu_hold = 0; m_dma_hold = 0;
    end else begin
      if (e_cr) m_cpu_hold = cpu_q.pop_front();
      if (e_dr) m_dma_hold = dma_q.pop_front();
      if (any) begin
        m_last_dma = e_dg;
        m_idx = e_idx;
        if (g_oob) m_err = 1;
        if (g_we) begin
          if (!g_oob) m_mem[e_idx] = g_wdata;
        end else if (e_dg) dma_q.push_back(g_oob ? 32'd0 : m_mem[e_idx]);
        else               cpu_q.push_back(g_oob ? 32'd0 : m_mem[e_idx]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                      input logic [31:0] cd, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    reset = r; cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWdata = cd;
    dmaReq = dr; dmaWe = dw; dmaAddr = da; dmaWdata = dd;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Mixed contention traffic: {cr, cw, caddr, cdata, dr, dw, daddr, ddata}
  logic        v_cr [8] = '{1, 1, 0, 1, 1, 0, 1, 0};
  logic        v_cw [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
  logic [31:0] v_ca [8] = '{32'h200, 32'h200, 0, 32'h208, 32'h204, 0, 32'h208, 0};
  logic [31:0] v_cd [8] = '{32'hCAFE0001, 0, 0, 32'hCAFE0003, 0, 0, 0, 0};
  logic        v_dr [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  logic        v_dw [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
  logic [31:0] v_da [8] = '{32'h204, 32'h204, 32'h20C, 0, 32'h200, 32'h20C, 32'h208, 0};
  logic [31:0] v_dd [8] = '{32'hD0D00002, 0, 32'hD0D00004, 0, 0, 0, 0, 0};

  logic [3:0] seq_c, seq_d, seq_s;

  initial begin
    do_reset();
    do_reset();

    // Reset state.
    idle();
    chk("rst_cpu_gnt", 32'(cpuGnt), 0);
    chk("rst_cpu_rvalid", 32'(cpuRvalid), 0);
    chk("rst_cpu_rdata", cpuRdata, 0);
    chk("rst_err", 32'(errOob), 0);
    chk("rst_index", 32'(memIndex), 0);
    chk("rst_last", 32'(dbgLastGnt), 1);

    // Store then load through the CPU port.
    step(0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("t1_st_gnt", 32'(cpuGnt), 1);
    chk("t1_st_we", 32'(memWrtEn), 1);
    chk("t1_st_idx", 32'(memIndex), 32'h40);
    step(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("t1_ld_gnt", 32'(cpuGnt), 1);
    idle();
    chk("t1_rvalid", 32'(cpuRvalid), 1);
    chk("t1_rdata", cpuRdata, 32'hDEADBEEF);
    idle();
    chk("t1_rvalid_pulse", 32'(cpuRvalid), 0);
    chk("t1_rdata_hold", cpuRdata, 32'hDEADBEEF);
    chk("t1_idx_hold", 32'(memIndex), 32'h40);

    // Both sides request for 4 cycles straight out of reset.
    do_reset();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    seq_c = 4'b1111; seq_d = 4'b0000; seq_s = 4'b0000;
`else
    seq_c = 4'b0101; seq_d = 4'b1010; seq_s = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
      chk("t2_cpu_gnt", 32'(cpuGnt), 32'(seq_c[i]));
      chk("t2_dma_gnt", 32'(dmaGnt), 32'(seq_d[i]));
      chk("t2_cpu_stall", 32'(cpuStall), 32'(seq_s[i]));
    end
    idle();
    idle();

    // DMA store, then a CPU load of the same word on the next cycle.
    step(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678);
    chk("t3_dma_gnt", 32'(dmaGnt), 1);
    step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    idle();
    chk("t3_rdata", cpuRdata, 32'h12345678);

    // Last in-range word, then out-of-range accesses.
    step(0, 1, 1, 32'h1FFC, 32'hA5A50001, 0, 0, 0, 0);
    chk("t4_top_we", 32'(memWrtEn), 1);
    chk("t4_top_idx", 32'(memIndex), 2047);
    step(0, 0, 0, 0, 0, 1, 0, 32'h1FFC, 0);
    idle();
    chk("t4_top_rdata", dmaRdata, 32'hA5A50001);
    chk("t4_err_clean", 32'(errOob), 0);
    step(0, 1, 0, 32'h2000, 0, 0, 0, 0, 0);
    chk("t4_oob_gnt", 32'(cpuGnt), 1);
    chk("t4_oob_we", 32'(memWrtEn), 0);
    idle();
    chk("t4_oob_rvalid", 32'(cpuRvalid), 1);
    chk("t4_oob_rdata", cpuRdata, 0);
    chk("t4_err", 32'(errOob), 1);
    step(0, 1, 1, 32'h2004, 32'hBADBAD00, 0, 0, 0, 0);
    chk("t4_oob_st_we", 32'(memWrtEn), 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
    idle();
    chk("t4_no_alias", dmaRdata, 0);
    chk("t4_err_sticky", 32'(errOob), 1);
    do_reset();
    idle();
    chk("t4_err_cleared", 32'(errOob), 0);

    // Reset the cycle after a granted load.
    step(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("t5_ld_gnt", 32'(cpuGnt), 1);
    step(1, 1, 1, 32'h100, 32'h0BAD0BAD, 1, 0, 0, 0);
    chk("t5_rvalid_masked", 32'(cpuRvalid), 0);
    chk("t5_no_write", 32'(memWrtEn), 0);
    chk("t5_no_gnt", 32'(cpuGnt | dmaGnt), 0);
    step(0, 1, 0, 32'h100, 0, 1, 0, 32'h40, 0);
    chk("t5_tie_cpu", 32'(cpuGnt), 1);
    chk("t5_no_late_rvalid", 32'(cpuRvalid), 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    idle();
    chk("t5_mem_intact", cpuRdata, 32'hDEADBEEF);

    // Both request 3 cycles, then the CPU drops out.
    do_reset();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    seq_c = 4'b0111;
`else
    seq_c = 4'b0101;
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, i < 3, 0, 32'h100, 0, 1, 0, 32'h40, 0);
      chk("t6_cpu_gnt", 32'(cpuGnt), 32'(seq_c[i]));
    end
    idle();
    idle();

    // Mixed traffic, including a request withdrawn before being granted.
    for (int i = 0; i < 8; i++)
      step(0, v_cr[i], v_cw[i], v_ca[i], v_cd[i], v_dr[i], v_dw[i], v_da[i], v_dd[i]);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
